nes_tetris_soc_mm_reader: RTL

NES_TETRIS_SOC_MM_READER -- requirements
Module: nes_tetris_soc_mm_reader

---
 rtl/nes_tetris_soc_mm_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nes_tetris_soc_mm_reader.sv
// Avalon-MM burst-less reader: fetches `length` words from base_addr and streams them out.
// Define NES_TETRIS_MM_READER_WRAP_EN to let addresses wrap instead of rejecting overruns.
module nes_tetris_soc_mm_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_err;
  logic                r_read;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                w_reject;
  logic                w_last;

`ifdef NES_TETRIS_MM_READER_WRAP_EN
  assign w_reject = 1'b0;
`else
  localparam int SW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [SW-1:0] LP_SPAN = SW'(1) << ADDR_W;
  logic [SW-1:0] w_end;
  // Transfer must fit below the top of the address space
  assign w_end    = SW'(base_addr) + SW'(length);
  assign w_reject = (w_end > LP_SPAN);
`endif

  assign w_last         = (r_cnt == (r_len - LEN_W'(1)));
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign err            = r_err;
  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_byteenable = '1;
  assign out_data       = r_data;
  assign out_valid      = r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_read  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else if (w_reject) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_addr  <= base_addr;
              r_len   <= length;
              r_cnt   <= '0;
              r_read  <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            r_read <= 1'b0;
            if (avm_readdatavalid) begin
              r_data  <= avm_readdata;
              r_valid <= 1'b1;
              r_state <= S_PUSH;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (avm_readdatavalid) begin
            r_data  <= avm_readdata;
            r_valid <= 1'b1;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_addr  <= r_addr + ADDR_W'(1);
            r_cnt   <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_read  <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
